// File: rtl/seq_divider.sv
// Sequential unsigned 16/8 restoring divider: one quotient bit per clock, start/done handshake.
// Optional feature macro: DIV_ZERO_FASTPATH_EN (zero divisor finishes without iterating).
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  count;
    logic [15:0] dvd_sh;
    logic [7:0]  dsr;
    logic [7:0]  rem;
    logic [15:0] quo;

    logic        accept;
    logic        zero_skip;
    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        take;
    logic [7:0]  rem_nx;
    logic [15:0] quo_nx;
    logic        last_iter;

    always_comb begin
        trial     = {rem, dvd_sh[15]};
        diff      = trial - {1'b0, dsr};
        take      = (trial >= {1'b0, dsr});
        rem_nx    = take ? diff[7:0] : trial[7:0];
        quo_nx    = {quo[14:0], take};
        last_iter = (count == 4'd15);
        accept    = start && (state != RUN);
`ifdef DIV_ZERO_FASTPATH_EN
        zero_skip = accept && (divisor == 8'd0);
`else
        zero_skip = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nx = zero_skip ? DONE : RUN;
                else
                    state_nx = IDLE;
            end
            RUN: begin
                if (last_iter)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            dvd_sh <= '0;
            dsr    <= '0;
            rem    <= '0;
            quo    <= '0;
            q      <= '0;
            r      <= '0;
            dz     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dvd_sh <= dividend;
                dsr    <= divisor;
                rem    <= '0;
                quo    <= '0;
                count  <= '0;
                // Zero divisor yields the same result the full iteration would produce.
                if (zero_skip) begin
                    q  <= '1;
                    r  <= dividend[7:0];
                    dz <= 1'b1;
                end
            end else if (state == RUN) begin
                dvd_sh <= {dvd_sh[14:0], 1'b0};
                rem    <= rem_nx;
                quo    <= quo_nx;
                count  <= count + 4'd1;
                if (last_iter) begin
                    q  <= quo_nx;
                    r  <= rem_nx;
                    dz <= (dsr == 8'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] prev_q   = '0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_EDGES = 0;
`else
    localparam int ZERO_EDGES = 16;
`endif

    seq_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Edges after the accepting edge are counted until done is seen; returns in the DONE cycle.
    task automatic await_done(input logic [15:0] a, input logic [7:0] b, input bit noise);
        int          exp_edges;
        int          n;
        bit          busy_ok;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        exp_edges = (b == 8'd0) ? ZERO_EDGES : 16;
        n       = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == 8) check("q_hold_during_run", q, prev_q);
            if (noise && n == 4) begin
                start    = 1'b1;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            if (noise && n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency_edges", n, exp_edges);
        check("busy_while_running", busy_ok, 1);
        check("busy_low_at_done", busy, 0);
        if (b == 8'd0) begin
            eq  = 16'hFFFF;
            er  = a[7:0];
            edz = 1'b1;
        end else begin
            eq  = a / b;
            er  = 8'(a % b);
            edz = 1'b0;
        end
        check("q", q, eq);
        check("r", r, er);
        check("dz", dz, edz);
        prev_q = eq;
    endtask

    task automatic op(input logic [15:0] a, input logic [7:0] b, input bit noise, input int gap);
        issue(a, b);
        await_done(a, b, noise);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (g == 0) begin
                check("done_single_pulse", done, 0);
                check("busy_idle_after_done", busy, 0);
            end
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        bit          seen_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_q", q, 0);
        check("reset_r", r, 0);
        check("reset_dz", dz, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(16'd1000, 8'd7, 1'b0, 2);
        op(16'hFFFF, 8'hFF, 1'b0, 1);
        op(16'hFFFF, 8'd1, 1'b0, 1);
        op(16'd5, 8'd9, 1'b0, 1);
        op(16'd1000, 8'd7, 1'b0, 0);
        op(16'd200, 8'd3, 1'b0, 1);
        op(16'hABCD, 8'd13, 1'b1, 1);
        op(16'h1234, 8'd0, 1'b0, 1);
        op(16'h1234, 8'd0, 1'b0, 0);
        op(16'd999, 8'd10, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'd0;
            op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Abort a division part-way with reset.
        @(posedge clk);
        #1;
        issue(16'd1000, 8'd7);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_q", q, 0);
        check("midrun_reset_r", r, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        check("no_activity_after_reset", seen_done, 0);
        prev_q = '0;
        op(16'd1000, 8'd7, 1'b0, 1);
        op(16'd200, 8'd3, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
